// File: rtl/jtag_debug_sysclk_sync_gen.sv
// System-clock side of the virtual-JTAG debug path: synchronises the TCK-domain
// update strobes, decodes update-DR into per-IR pulses and queues commands.
module jtag_debug_sysclk_sync_gen #(
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned DR_WIDTH    = 38,
  parameter int unsigned ACT_BIT     = 37,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned NUM_IR     = 2 ** IR_WIDTH,
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [DR_WIDTH-1:0] sr,
  input  logic                uir_toggle,
  input  logic                udr_toggle,
  output logic [DR_WIDTH-1:0] jdo,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [NUM_IR-1:0]   take_action,
  output logic [NUM_IR-1:0]   take_no_action,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [DR_WIDTH-1:0] cmd_data,
  output logic [LW-1:0]       fifo_level,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] WARM_CYCLES = CW'(SYNC_STAGES + 1);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_hist;
  logic                   udr_hist;
  logic                   uir_evt;
  logic                   udr_evt;
  logic [CW-1:0]          warm_cnt;
  logic                   warm_done;

  assign warm_done = (warm_cnt == WARM_CYCLES);

  // History flops track the synchronised toggle even during warm-up, so a
  // toggle already at 1 when reset releases is absorbed without an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_hist <= 1'b0;
      udr_hist <= 1'b0;
      uir_evt  <= 1'b0;
      udr_evt  <= 1'b0;
      warm_cnt <= '0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], uir_toggle};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], udr_toggle};
      uir_hist <= uir_sync[SYNC_STAGES-1];
      udr_hist <= udr_sync[SYNC_STAGES-1];
      uir_evt  <= (uir_sync[SYNC_STAGES-1] ^ uir_hist) & warm_done;
      udr_evt  <= (udr_sync[SYNC_STAGES-1] ^ udr_hist) & warm_done;
      if (!warm_done) warm_cnt <= warm_cnt + CW'(1);
    end
  end

  // Decode uses the pre-edge ir_q, so a coincident update-IR only affects
  // the following update-DR.
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo            <= '0;
      ir_q           <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (uir_evt) ir_q <= ir_in;
      if (udr_evt) begin
        jdo                  <= sr;
        take_action[ir_q]    <= sr[ACT_BIT];
        take_no_action[ir_q] <= ~sr[ACT_BIT];
      end
    end
  end

  logic [IR_WIDTH-1:0] mem_ir   [FIFO_DEPTH];
  logic [DR_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                full;
  logic                pop;
  logic                do_push;
  logic                drop;

  assign cmd_valid = (fifo_level != '0);
  assign full      = (fifo_level == FULL_LEVEL);
  assign pop       = cmd_valid & cmd_ready;
  assign do_push   = udr_evt & (~full | pop);
  assign drop      = udr_evt & full & ~pop;
  assign cmd_ir    = mem_ir[rd_ptr];
  assign cmd_data  = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_ir[wr_ptr]   <= ir_q;
      mem_data[wr_ptr] <= sr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: doc/jtag_debug_sysclk_sync_gen.md
Name: jtag_debug_sysclk_sync_gen

Overview:
Parametrised system-clock-side receiver for the Nios II virtual-JTAG debug path. It takes the TCK-domain instruction register, data shift register and update-IR/update-DR toggle strobes, and synchronises the strobes into clk. It decodes each update-DR into per-instruction take_action / take_no_action pulses and queues every command in a small FIFO with a valid/ready handshake. It generalises the fixed 2-bit IR / 38-bit DR sysclk stage with configurable widths, synchroniser depth and buffering, plus overflow reporting.

Parameters:
IR_WIDTH, 2, instruction register width; NUM_IR = 2**IR_WIDTH derived.
DR_WIDTH, 38, data shift register width.
ACT_BIT, 37, sr bit that selects action (1) vs no-action (0); must be < DR_WIDTH.
SYNC_STAGES, 2, synchroniser flops per toggle strobe; must be >= 2.
FIFO_DEPTH, 4, command queue entries; power of 2, >= 2; LW = log2(FIFO_DEPTH)+1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
ir_in  in  IR_WIDTH  TCK-domain IR value; stable around uir_toggle changes
sr  in  DR_WIDTH  TCK-domain shift register; stable for >= SYNC_STAGES+3 clk cycles after a udr_toggle change
uir_toggle  in  1  inverts once per update-IR (async to clk)
udr_toggle  in  1  inverts once per update-DR (async to clk)
jdo  out  DR_WIDTH  last captured sr
ir_q  out  IR_WIDTH  last captured ir_in
take_action  out  NUM_IR  one-cycle pulse, bit i = update-DR with IR==i and sr[ACT_BIT]=1
take_no_action  out  NUM_IR  one-cycle pulse, bit i = update-DR with IR==i and sr[ACT_BIT]=0
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer accepts head
cmd_ir  out  IR_WIDTH  head IR
cmd_data  out  DR_WIDTH  head data
fifo_level  out  LW  occupied entries
overflow  out  1  sticky: a command was dropped
clear_overflow  in  1  clears overflow

Behaviour:
- Reset (sync, active-high): all sync flops, edge-history flops, jdo, ir_q, take_action, take_no_action, FIFO pointers and overflow go to 0. fifo_level=0, cmd_valid=0. Reset mid-operation discards queued commands and any in-flight event.
- Warm-up counter: after reset deasserts, event detection is suppressed for SYNC_STAGES+1 cycles. During this window the edge-history flop tracks the synchronised toggle, so a toggle sitting at 1 never produces a spurious event.
- Event detect, per strobe: SYNC_STAGES-flop chain, then a history flop. The event register evt_q <= sync_last ^ hist, gated by warm-up done. This gives one event per toggle change, including back-to-back changes spaced >= 2 clk cycles apart.
- uir event: ir_q <= ir_in at the edge after evt_q is high.
- udr event, at the edge after evt_q is high:
  - jdo <= sr.
  - take_action[ir_q] <= sr[ACT_BIT] and take_no_action[ir_q] <= ~sr[ACT_BIT]; all other bits 0. Outputs are high for exactly one cycle.
  - Push {ir_q, sr} into the FIFO.
- uir and udr events in the same cycle: the udr decode uses the old ir_q, and ir_q updates in the same edge.
- Latency: a toggle change before edge k gives jdo / take_* / push visible after edge k+SYNC_STAGES+1.
- FIFO: cmd_valid = level!=0; cmd_ir/cmd_data show the head combinationally from storage. Pop occurs on cmd_valid & cmd_ready.
  - Push when full without a pop in the same cycle: entry dropped, contents unchanged, overflow <= 1. jdo and take_* still update.
  - Push and pop together when full: both happen, no overflow, level unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set dominates clear_overflow in the same cycle. Otherwise clear_overflow=1 gives 0 next cycle.
- fifo_level is registered, range 0..FIFO_DEPTH.

Test Plan:
- Reset with udr_toggle=1 held, release -> no take_* pulse, fifo_level=0 for 20 cycles.
- uir_toggle 0->1 with ir_in=2'b01, then udr_toggle 0->1 with sr=38'h20_0000_1234 -> after 3 cycles take_action=4'b0010 for one cycle, jdo=38'h20_0000_1234, cmd_valid=1, cmd_ir=1.
- ir_q=3, sr[37]=0, udr toggle -> take_no_action=4'b1000 one cycle, take_action=0.
- cmd_ready=0, 5 udr events with sr=1..5 (FIFO_DEPTH=4) -> fifo_level=4, overflow=1. Pop all -> cmd_data sequence 1,2,3,4.
- Full FIFO, cmd_ready=1 coincident with 5th push -> overflow stays 0, level stays 4. Then clear_overflow pulse after a real drop -> overflow=0 next cycle.
- Assert reset with 3 entries queued and an event mid-synchroniser -> level=0, no pulse after release; the next toggle decodes normally.
